lfsr_stream_gen: RTL and testbench



---
 rtl/lfsr_pkg.sv | 42 ++++
 rtl/lfsr_step.sv | 31 +++
 rtl/lfsr_stream_gen.sv | 239 +++++++++++++++++++++++
 tb/tb_lfsr_stream_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared types and constants for the LFSR stream generator:
//   - lfsr_mode_e  : feedback structure (Fibonacci / Galois)
//   - lfsr_state_e : word-generation FSM states
//   - default feedback masks per width and the default seed
// -----------------------------------------------------------------------------
package lfsr_pkg;

  typedef enum logic {
    MODE_FIB = 1'b0,
    MODE_GAL = 1'b1
  } lfsr_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } lfsr_state_e;

  localparam logic [31:0] LFSR_TAPS_W4  = 32'h0000_000C;
  localparam logic [31:0] LFSR_TAPS_W8  = 32'h0000_00B8;
  localparam logic [31:0] LFSR_TAPS_W16 = 32'h0000_B400;
  localparam logic [31:0] LFSR_TAPS_W32 = 32'h8020_0003;

  localparam logic [31:0] LFSR_DEFAULT_SEED = 32'h0000_ACE1;

  // Maximal-length masks for the common widths; other widths fall back to
  // the two top bits, which is nonzero but not guaranteed maximal.
  function automatic logic [31:0] lfsr_default_taps(input int w);
    logic [31:0] t;
    case (w)
      32'sd4:  t = LFSR_TAPS_W4;
      32'sd8:  t = LFSR_TAPS_W8;
      32'sd16: t = LFSR_TAPS_W16;
      32'sd32: t = LFSR_TAPS_W32;
      default: t = 32'h0000_0003 << (w - 32'sd2);
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// -----------------------------------------------------------------------------
// lfsr_step
// Purely combinational LFSR next-state function.
// Ports:
//   s    in  WIDTH  current state
//   taps in  WIDTH  feedback mask
//   mode in  1      MODE_FIB / MODE_GAL
//   next out WIDTH  next state (no zero substitution here)
// -----------------------------------------------------------------------------
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] taps,
  input  lfsr_mode_e       mode,
  output logic [WIDTH-1:0] next
);

  // Select Fibonacci (shift left, parity feedback) or Galois (shift right, masked xor)
  always_comb begin
    next = s;
    case (mode)
      MODE_FIB: next = {s[WIDTH-2:0], ^(s & taps)};
      MODE_GAL: next = {1'b0, s[WIDTH-1:1]} ^ ({WIDTH{s[0]}} & taps);
      default:  next = s;
    endcase
  end

endmodule

// File: rtl/lfsr_stream_gen.sv
// -----------------------------------------------------------------------------
// lfsr_stream_gen
// Width-generic Fibonacci/Galois LFSR emitting one word per `steps` shifts on
// a valid/ready stream. Seed, taps, mode and steps are captured by load_i.
// Optional feature macro: LFSR_PERIOD_CNT_EN (adds period_cnt_o/period_wrap_o).
// Ports:
//   wb_clk_i     in   1       clock
//   wb_rst_i     in   1       asynchronous active-high reset
//   load_i       in   1       capture seed_i/taps_i/mode_i/steps_i, abort any word
//   seed_i       in   WIDTH   seed (0 -> SEED, sets lockup_o)
//   taps_i       in   WIDTH   feedback mask (0 -> TAPS)
//   mode_i       in   1       0 Fibonacci, 1 Galois
//   steps_i      in   STEP_W  shifts per word (0 -> 1, >WIDTH -> WIDTH)
//   run_i        in   1       enable word generation
//   out_data_o   out  WIDTH   emitted word
//   out_valid_o  out  1       stream valid
//   out_ready_i  in   1       stream ready
//   busy_o       out  1       FSM in SHIFT or HOLD
//   lockup_o     out  1       sticky zero-state substitution flag
//   period_cnt_o out  32      (LFSR_PERIOD_CNT_EN) shifts per observed period
//   period_wrap_o out 1       (LFSR_PERIOD_CNT_EN) pulse when state returns to seed
// -----------------------------------------------------------------------------
module lfsr_stream_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH  = 16,
  parameter logic [WIDTH-1:0] TAPS   = WIDTH'(lfsr_default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED   = WIDTH'(LFSR_DEFAULT_SEED),
  parameter int               STEP_W = $clog2(WIDTH) + 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              load_i,
  input  logic [WIDTH-1:0]  seed_i,
  input  logic [WIDTH-1:0]  taps_i,
  input  logic              mode_i,
  input  logic [STEP_W-1:0] steps_i,
  input  logic              run_i,
  output logic [WIDTH-1:0]  out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              lockup_o
`ifdef LFSR_PERIOD_CNT_EN
  ,
  output logic [31:0]       period_cnt_o,
  output logic              period_wrap_o
`endif
);

  localparam logic [STEP_W-1:0] CNT_ZERO = STEP_W'(0);
  localparam logic [STEP_W-1:0] CNT_ONE  = STEP_W'(1);
  localparam logic [STEP_W-1:0] CNT_MAX  = STEP_W'(WIDTH);
  localparam logic [WIDTH-1:0]  ZERO_W   = WIDTH'(0);

  lfsr_state_e       state_r, state_nxt_s;
  lfsr_mode_e        mode_r;
  logic [WIDTH-1:0]  lfsr_r, taps_r, out_data_r;
  logic [WIDTH-1:0]  lfsr_next_s, lfsr_fixed_s, taps_eff_s, seed_eff_s;
  logic [STEP_W-1:0] steps_r, cnt_r, steps_eff_s;
  logic              out_valid_r, busy_r, lockup_r;
  logic              shift_s, emit_s, take_s, cnt_load_s;
  logic              next_zero_s, seed_zero_s;

  lfsr_step #(.WIDTH(WIDTH)) u_step (
    .s    (lfsr_r),
    .taps (taps_r),
    .mode (mode_r),
    .next (lfsr_next_s)
  );

  // Zero-state substitution and load-time config normalisation
  always_comb begin
    next_zero_s  = (lfsr_next_s == ZERO_W);
    lfsr_fixed_s = next_zero_s ? SEED : lfsr_next_s;
    seed_zero_s  = (seed_i == ZERO_W);
    seed_eff_s   = seed_zero_s ? SEED : seed_i;
    taps_eff_s   = (taps_i == ZERO_W) ? TAPS : taps_i;
    if (steps_i == CNT_ZERO) begin
      steps_eff_s = CNT_ONE;
    end else if (steps_i > CNT_MAX) begin
      steps_eff_s = CNT_MAX;
    end else begin
      steps_eff_s = steps_i;
    end
  end

  // FSM state register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state and datapath strobes; load_i overrides every state
  always_comb begin
    state_nxt_s = state_r;
    shift_s     = 1'b0;
    emit_s      = 1'b0;
    take_s      = 1'b0;
    cnt_load_s  = 1'b0;
    if (load_i) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (run_i) begin
            state_nxt_s = ST_SHIFT;
            cnt_load_s  = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          shift_s = 1'b1;
          if (cnt_r == CNT_ONE) begin
            emit_s      = 1'b1;
            state_nxt_s = ST_HOLD;
          end else begin
            state_nxt_s = ST_SHIFT;
          end
        end
        ST_HOLD: begin
          if (out_valid_r && out_ready_i) begin
            take_s = 1'b1;
            if (run_i) begin
              state_nxt_s = ST_SHIFT;
              cnt_load_s  = 1'b1;
            end else begin
              state_nxt_s = ST_IDLE;
            end
          end else begin
            state_nxt_s = ST_HOLD;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // LFSR state, config capture, output word and sticky lockup flag
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      lfsr_r      <= SEED;
      taps_r      <= TAPS;
      mode_r      <= MODE_FIB;
      steps_r     <= CNT_ONE;
      out_data_r  <= ZERO_W;
      out_valid_r <= 1'b0;
      lockup_r    <= 1'b0;
    end else if (load_i) begin
      lfsr_r      <= seed_eff_s;
      taps_r      <= taps_eff_s;
      mode_r      <= lfsr_mode_e'(mode_i);
      steps_r     <= steps_eff_s;
      out_valid_r <= 1'b0;
      lockup_r    <= seed_zero_s;
    end else begin
      if (shift_s) begin
        lfsr_r <= lfsr_fixed_s;
        if (next_zero_s) begin
          lockup_r <= 1'b1;
        end
      end
      if (emit_s) begin
        out_data_r  <= lfsr_fixed_s;
        out_valid_r <= 1'b1;
      end else if (take_s) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  // Shift countdown for the word in progress
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt_r <= CNT_ONE;
    end else if (cnt_load_s) begin
      cnt_r <= steps_r;
    end else if (shift_s) begin
      cnt_r <= cnt_r - CNT_ONE;
    end
  end

  // busy_o is registered from the next state so it tracks state_r exactly
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != ST_IDLE);
    end
  end

  assign out_data_o  = out_data_r;
  assign out_valid_o = out_valid_r;
  assign busy_o      = busy_r;
  assign lockup_o    = lockup_r;

`ifdef LFSR_PERIOD_CNT_EN
  localparam logic [31:0] PCNT_MAX = 32'hFFFF_FFFF;

  logic [WIDTH-1:0] eff_seed_r;
  logic [31:0]      run_cnt_r, period_cnt_r;
  logic             period_wrap_r;

  // Shift counter since load; latches period length when state returns to the seed
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      eff_seed_r    <= SEED;
      run_cnt_r     <= 32'h0000_0000;
      period_cnt_r  <= 32'h0000_0000;
      period_wrap_r <= 1'b0;
    end else if (load_i) begin
      eff_seed_r    <= seed_eff_s;
      run_cnt_r     <= 32'h0000_0000;
      period_wrap_r <= 1'b0;
    end else begin
      period_wrap_r <= 1'b0;
      if (shift_s) begin
        if (lfsr_fixed_s == eff_seed_r) begin
          period_wrap_r <= 1'b1;
          period_cnt_r  <= (run_cnt_r == PCNT_MAX) ? PCNT_MAX : run_cnt_r + 32'h0000_0001;
          run_cnt_r     <= 32'h0000_0000;
        end else if (run_cnt_r != PCNT_MAX) begin
          run_cnt_r <= run_cnt_r + 32'h0000_0001;
        end
      end
    end
  end

  assign period_cnt_o  = period_cnt_r;
  assign period_wrap_o = period_wrap_r;
`endif

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// -----------------------------------------------------------------------------
// tb_lfsr_stream_gen
// Directed bench for lfsr_stream_gen (WIDTH=16). Inputs change 1 time unit
// after the rising edge and outputs are sampled at the same point.
// With LFSR_PERIOD_CNT_EN defined a second WIDTH=4 instance checks the period
// counter.
// -----------------------------------------------------------------------------
module tb_lfsr_stream_gen;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        load_i = 1'b0;
  logic [15:0] seed_i = 16'h0000;
  logic [15:0] taps_i = 16'h0000;
  logic        mode_i = 1'b0;
  logic [4:0]  steps_i = 5'd0;
  logic        run_i = 1'b0;
  logic        out_ready_i = 1'b0;
  logic [15:0] out_data_o;
  logic        out_valid_o;
  logic        busy_o;
  logic        lockup_o;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 wb_clk_i = ~wb_clk_i;

`ifdef LFSR_PERIOD_CNT_EN
  logic [31:0] period_cnt_s;
  logic        period_wrap_s;
  logic        load4_i = 1'b0;
  logic [3:0]  seed4_i = 4'h0;
  logic [3:0]  taps4_i = 4'h0;
  logic [2:0]  steps4_i = 3'd0;
  logic        run4_i = 1'b0;
  logic        ready4_i = 1'b0;
  logic [3:0]  data4_o;
  logic        valid4_o, busy4_o, lockup4_o;
  logic [31:0] period_cnt4_o;
  logic        period_wrap4_o;
`endif

  lfsr_stream_gen #(.WIDTH(16)) u_dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .load_i      (load_i),
    .seed_i      (seed_i),
    .taps_i      (taps_i),
    .mode_i      (mode_i),
    .steps_i     (steps_i),
    .run_i       (run_i),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .busy_o      (busy_o),
    .lockup_o    (lockup_o)
`ifdef LFSR_PERIOD_CNT_EN
    ,
    .period_cnt_o  (period_cnt_s),
    .period_wrap_o (period_wrap_s)
`endif
  );

`ifdef LFSR_PERIOD_CNT_EN
  lfsr_stream_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1)) u_dut4 (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .load_i        (load4_i),
    .seed_i        (seed4_i),
    .taps_i        (taps4_i),
    .mode_i        (1'b0),
    .steps_i       (steps4_i),
    .run_i         (run4_i),
    .out_data_o    (data4_o),
    .out_valid_o   (valid4_o),
    .out_ready_i   (ready4_i),
    .busy_o        (busy4_o),
    .lockup_o      (lockup4_o),
    .period_cnt_o  (period_cnt4_o),
    .period_wrap_o (period_wrap4_o)
  );
`endif

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] seed, input logic [15:0] taps,
                         input logic mode, input logic [4:0] steps);
    load_i  = 1'b1;
    seed_i  = seed;
    taps_i  = taps;
    mode_i  = mode;
    steps_i = steps;
    tick();
    load_i  = 1'b0;
  endtask

  function automatic logic [15:0] fib16(input logic [15:0] s, input logic [15:0] t);
    return {s[14:0], ^(s & t)};
  endfunction

  logic [15:0] exp_w;

  initial begin
    repeat (3) tick();
    wb_rst_i = 1'b0;
    tick();
    check("rst_data", 32'(out_data_o), 32'h0);
    check("rst_valid", 32'(out_valid_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_lockup", 32'(lockup_o), 32'h0);

    // Fibonacci, steps=1, constant ready
    do_load(16'hACE1, 16'hB400, 1'b0, 5'd1);
    run_i = 1'b1; out_ready_i = 1'b1;
    tick();
    check("fib_lat_valid", 32'(out_valid_o), 32'h0);
    check("fib_lat_busy", 32'(busy_o), 32'h1);
    tick();
    check("fib_w1_valid", 32'(out_valid_o), 32'h1);
    check("fib_w1_data", 32'(out_data_o), 32'h59C3);
    tick();
    check("fib_hs_valid", 32'(out_valid_o), 32'h0);
    tick();
    check("fib_w2_valid", 32'(out_valid_o), 32'h1);
    check("fib_w2_data", 32'(out_data_o), 32'hB387);
    run_i = 1'b0;
    tick();
    check("fib_idle_valid", 32'(out_valid_o), 32'h0);
    check("fib_idle_busy", 32'(busy_o), 32'h0);

    // Galois
    do_load(16'hACE1, 16'hB400, 1'b1, 5'd1);
    run_i = 1'b1;
    tick(); tick();
    check("gal_w1_valid", 32'(out_valid_o), 32'h1);
    check("gal_w1_data", 32'(out_data_o), 32'hE270);
    run_i = 1'b0;
    tick();
    check("gal_idle_busy", 32'(busy_o), 32'h0);

    // Zero seed substitution, then cleared by a nonzero seed
    do_load(16'h0000, 16'hB400, 1'b0, 5'd1);
    check("zseed_lockup", 32'(lockup_o), 32'h1);
    run_i = 1'b1;
    tick(); tick();
    check("zseed_data", 32'(out_data_o), 32'h59C3);
    run_i = 1'b0;
    tick();
    do_load(16'h0001, 16'hB400, 1'b0, 5'd1);
    check("zseed_clear", 32'(lockup_o), 32'h0);

    // Computed zero next state: taps=0x0001 shifts 0x8000 to 0
    do_load(16'h8000, 16'h0001, 1'b0, 5'd1);
    check("znext_pre_lockup", 32'(lockup_o), 32'h0);
    run_i = 1'b1;
    tick(); tick();
    check("znext_data", 32'(out_data_o), 32'hACE1);
    check("znext_lockup", 32'(lockup_o), 32'h1);
    run_i = 1'b0;
    tick();

    // steps=0 acts as 1, taps=0 selects the default mask
    do_load(16'hACE1, 16'h0000, 1'b0, 5'd0);
    run_i = 1'b1;
    tick(); tick();
    check("s0_valid", 32'(out_valid_o), 32'h1);
    check("s0_data", 32'(out_data_o), 32'h59C3);
    run_i = 1'b0;
    tick();

    // steps=31 clamps to 16
    do_load(16'hACE1, 16'hB400, 1'b0, 5'd31);
    exp_w = 16'hACE1;
    for (int i = 0; i < 16; i++) exp_w = fib16(exp_w, 16'hB400);
    run_i = 1'b1;
    tick();
    repeat (15) tick();
    check("clamp_early_valid", 32'(out_valid_o), 32'h0);
    tick();
    check("clamp_valid", 32'(out_valid_o), 32'h1);
    check("clamp_data", 32'(out_data_o), 32'(exp_w));
    run_i = 1'b0;
    tick();

    // steps=4 with a 10-cycle stall
    out_ready_i = 1'b0;
    do_load(16'hACE1, 16'hB400, 1'b0, 5'd4);
    run_i = 1'b1;
    tick();
    repeat (3) tick();
    check("st_early_valid", 32'(out_valid_o), 32'h0);
    tick();
    check("st_w1_valid", 32'(out_valid_o), 32'h1);
    check("st_w1_data", 32'(out_data_o), 32'hCE1E);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("st_hold_valid", 32'(out_valid_o), 32'h1);
      check("st_hold_data", 32'(out_data_o), 32'hCE1E);
    end
    out_ready_i = 1'b1;
    tick();
    check("st_hs_valid", 32'(out_valid_o), 32'h0);
    out_ready_i = 1'b0;
    repeat (3) tick();
    check("st_gap_valid", 32'(out_valid_o), 32'h0);
    tick();
    check("st_w2_valid", 32'(out_valid_o), 32'h1);
    check("st_w2_data", 32'(out_data_o), 32'hE1E4);

    // load in HOLD with a simultaneous handshake: load wins, word dropped
    run_i = 1'b0;
    out_ready_i = 1'b1;
    do_load(16'hACE1, 16'hB400, 1'b0, 5'd1);
    check("abort_valid", 32'(out_valid_o), 32'h0);
    check("abort_busy", 32'(busy_o), 32'h0);
    tick();
    check("abort_idle_valid", 32'(out_valid_o), 32'h0);
    check("abort_idle_busy", 32'(busy_o), 32'h0);
    run_i = 1'b1;
    tick(); tick();
    check("abort_next_data", 32'(out_data_o), 32'h59C3);
    run_i = 1'b0;
    tick();

`ifdef LFSR_PERIOD_CNT_EN
    begin
      int wraps;
      int first_at;
      wraps = 0;
      first_at = 0;
      load4_i = 1'b1; seed4_i = 4'h1; taps4_i = 4'hC; steps4_i = 3'd1;
      tick();
      load4_i = 1'b0; run4_i = 1'b1; ready4_i = 1'b1;
      for (int i = 0; i < 100; i++) begin
        tick();
        if (period_wrap4_o) begin
          check("per_cnt", period_cnt4_o, 32'd15);
          if (wraps == 0) first_at = i;
          else if (wraps == 1) check("per_spacing", 32'(i - first_at), 32'd30);
          wraps++;
        end
      end
      check("per_wrap_seen", 32'(wraps >= 2), 32'h1);
      run4_i = 1'b0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
